// File: rtl/pmem_responder_if.sv
// Cache-line memory port between a requester and the pmem responder.
// master: requester side (drives address/request/write data)
// slave : responder side (drives read data, completion pulse, busy)
interface pmem_responder_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;

    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              busy;

    modport master (
        output pmem_address,
        output pmem_read,
        output pmem_write,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp,
        input  busy
    );

    modport slave (
        input  pmem_address,
        input  pmem_read,
        input  pmem_write,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp,
        output busy
    );
endinterface

// File: rtl/pmem_responder.sv
// Memory-side responder for a 128-bit cache-line interface with a fixed
// request-to-response latency.
// Ports:
//   clk     - single clock, rising edge
//   reset_n - asynchronous active-low reset; clears state, outputs and storage
//   bus     - pmem_responder_if.slave: address/read/write/wdata in,
//             rdata/resp/busy out (all outputs registered)
// Parameters:
//   LATENCY - edges from acceptance to pmem_resp (1..15)
//   LINES   - number of stored lines (power of two, 2..256)
module pmem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned LINES   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    pmem_responder_if.slave  bus
);
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned OFS_W  = 4;
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               resp_q, resp_d;
    logic               busy_q, busy_d;
    logic               accept_c;
    logic               commit_c;

    logic [IDX_W-1:0]   idx_q;
    logic               wr_q;
    logic               rd_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  rdata_q;
    logic [LINE_W-1:0]  mem_q [LINES];

    logic [IDX_W-1:0]   req_idx_c;
    logic               req_any_c;

    // Offset bits and aliased upper bits never select storage.
    logic               unused_addr_bits;
    assign unused_addr_bits = ^{bus.pmem_address[ADDR_W-1:OFS_W+IDX_W],
                                bus.pmem_address[OFS_W-1:0]};

    assign req_idx_c = bus.pmem_address[OFS_W +: IDX_W];
    assign req_any_c = bus.pmem_read | bus.pmem_write;

    // State and control output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and next-output decode.
    // The counter is loaded with LATENCY-1 and WAIT completes on the edge
    // that sees it at zero, so resp rises exactly LATENCY edges after
    // acceptance; with LATENCY=1 the zero-loaded counter completes on the
    // very next edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        resp_d   = 1'b0;
        busy_d   = busy_q;
        accept_c = 1'b0;
        commit_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_any_c) begin
                    accept_c = 1'b1;
                    cnt_d    = CNT_W'(LATENCY - 1);
                    busy_d   = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit_c = 1'b1;
                    resp_d   = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // No acceptance here; the next request is taken from IDLE.
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Request capture, line storage and read-data register.
    // A combined read+write commits the write and returns the written data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (accept_c) begin
                idx_q   <= req_idx_c;
                wr_q    <= bus.pmem_write;
                rd_q    <= bus.pmem_read;
                wdata_q <= bus.pmem_wdata;
            end
            if (commit_c) begin
                if (wr_q) begin
                    mem_q[idx_q] <= wdata_q;
                end
                if (rd_q) begin
                    rdata_q <= wr_q ? wdata_q : mem_q[idx_q];
                end
            end
        end
    end

    assign bus.pmem_rdata = rdata_q;
    assign bus.pmem_resp  = resp_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder (LATENCY=4, LINES=32).
module tb_pmem_responder;
    localparam int unsigned LAT   = 4;
    localparam int unsigned NLINE = 32;

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DA = 128'hAAAA_5555_AAAA_5555_1111_2222_3333_4444;
    localparam logic [127:0] DB = 128'hBBBB_0000_CCCC_1111_DDDD_2222_EEEE_3333;
    localparam logic [127:0] DC = 128'hC0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0_C0C0;
    localparam logic [127:0] DE = 128'hE0E1_E2E3_E4E5_E6E7_E8E9_EAEB_ECED_EEEF;
    localparam logic [127:0] DF = 128'hF0F1_F2F3_F4F5_F6F7_F8F9_FAFB_FCFD_FEFF;
    localparam logic [127:0] DJ = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    pmem_responder_if bus ();

    pmem_responder #(
        .LATENCY (LAT),
        .LINES   (NLINE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic rd, input logic wr, input logic [127:0] wd);
        bus.pmem_address = a;
        bus.pmem_read    = rd;
        bus.pmem_write   = wr;
        bus.pmem_wdata   = wd;
    endtask

    // Called right after the acceptance edge; counts edges until resp.
    task automatic wait_resp(input string tag, input logic [127:0] exp_rd);
        int edges;
        edges = 0;
        check({tag, "_busy_acc"}, 128'(bus.busy), 128'(1));
        check({tag, "_resp_acc"}, 128'(bus.pmem_resp), 128'(0));
        while (edges < 20 && bus.pmem_resp !== 1'b1) begin
            tick();
            edges++;
        end
        check({tag, "_lat"}, 128'(edges), 128'(LAT));
        check({tag, "_rdata"}, bus.pmem_rdata, exp_rd);
    endtask

    task automatic do_req(input string tag, input logic [15:0] a, input logic rd,
                          input logic wr, input logic [127:0] wd, input logic [127:0] exp_rd);
        drive(a, rd, wr, wd);
        tick();
        wait_resp(tag, exp_rd);
        drive(16'h0, 1'b0, 1'b0, '0);
        tick();
        check({tag, "_resp_off"}, 128'(bus.pmem_resp), 128'(0));
        check({tag, "_busy_off"}, 128'(bus.busy), 128'(0));
        check({tag, "_rdata_hold"}, bus.pmem_rdata, exp_rd);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        drive(16'h0, 1'b0, 1'b0, '0);
        tick();
        tick();
        check("rst_resp",  128'(bus.pmem_resp), 128'(0));
        check("rst_busy",  128'(bus.busy), 128'(0));
        check("rst_rdata", bus.pmem_rdata, 128'(0));
        reset_n = 1'b1;

        // Idle with no request: nothing moves
        tick();
        tick();
        check("idle_busy", 128'(bus.busy), 128'(0));
        check("idle_resp", 128'(bus.pmem_resp), 128'(0));

        // Read of cleared storage
        do_req("rd0040", 16'h0040, 1'b1, 1'b0, '0, 128'(0));

        // Write then read with nonzero offset bits
        do_req("wr0120", 16'h0120, 1'b0, 1'b1, D1, 128'(0));
        do_req("rd012C", 16'h012C, 1'b1, 1'b0, '0, D1);

        // Aliasing: 0x0200 maps to line 0 with 32 lines
        do_req("wr0200", 16'h0200, 1'b0, 1'b1, DA, D1);
        do_req("rd0000", 16'h0000, 1'b1, 1'b0, '0, DA);
        do_req("rd0010", 16'h0010, 1'b1, 1'b0, '0, 128'(0));

        // Read and write together act as a write returning the written data
        do_req("rw0030", 16'h0030, 1'b1, 1'b1, DB, DB);
        do_req("rd0030", 16'h0030, 1'b1, 1'b0, '0, DB);
        do_req("rd0120", 16'h0120, 1'b1, 1'b0, '0, D1);

        // Reset in the middle of WAIT aborts the pending write
        drive(16'h0050, 1'b0, 1'b1, DC);
        tick();
        check("abort_busy_acc", 128'(bus.busy), 128'(1));
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("abort_resp",  128'(bus.pmem_resp), 128'(0));
        check("abort_busy",  128'(bus.busy), 128'(0));
        check("abort_rdata", bus.pmem_rdata, 128'(0));
        tick();
        tick();
        tick();
        check("abort_resp_held", 128'(bus.pmem_resp), 128'(0));
        drive(16'h0, 1'b0, 1'b0, '0);
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", 128'(bus.busy), 128'(0));
        do_req("rd0050", 16'h0050, 1'b1, 1'b0, '0, 128'(0));
        do_req("rd0030_clr", 16'h0030, 1'b1, 1'b0, '0, 128'(0));

        // Captured values survive input changes; held read is re-accepted
        do_req("wr0060", 16'h0060, 1'b0, 1'b1, DE, 128'(0));
        do_req("wr0070", 16'h0070, 1'b0, 1'b1, DF, 128'(0));
        drive(16'h0060, 1'b1, 1'b0, '0);
        tick();
        check("b2b_busy_acc", 128'(bus.busy), 128'(1));
        tick();
        bus.pmem_address = 16'h0070;
        bus.pmem_wdata   = DJ;
        begin
            int edges;
            edges = 1;
            while (edges < 20 && bus.pmem_resp !== 1'b1) begin
                tick();
                edges++;
            end
            check("b2b1_lat", 128'(edges), 128'(LAT));
        end
        check("b2b1_rdata", bus.pmem_rdata, DE);
        tick();
        check("b2b_resp_off", 128'(bus.pmem_resp), 128'(0));
        check("b2b_busy_gap", 128'(bus.busy), 128'(0));
        tick();
        wait_resp("b2b2", DF);
        drive(16'h0, 1'b0, 1'b0, '0);
        tick();
        check("b2b2_busy_off", 128'(bus.busy), 128'(0));
        do_req("rd0070_chk", 16'h0070, 1'b1, 1'b0, '0, DF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
